// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one W-bit integer ALU, one operation in flight.
// Optional ALU_ARB_FAST_EN: skip EXEC and compute from the request port in the grant cycle.
module alu_arbiter #(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         busy,
  output logic         grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           grant_q, grant_d;
  logic [W-1:0]   res_q, res_d;
`ifndef ALU_ARB_FAST_EN
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
`endif

  logic           sel, fire, rsp_fire;
  logic [2:0]     sel_op;
  logic [W-1:0]   sel_a, sel_b;

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a ^ b;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = a << b[SHW-1:0];
      3'b110: r = a >> b[SHW-1:0];
      3'b111: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Uncontested: the lone requester wins; idle with no request: prio owns ready.
  always_comb begin
    if (req0_valid && req1_valid) sel = prio_q;
    else if (req0_valid)          sel = 1'b0;
    else if (req1_valid)          sel = 1'b1;
    else                          sel = prio_q;
  end

  assign req0_ready = (state_q == IDLE) && !sel;
  assign req1_ready = (state_q == IDLE) &&  sel;
  assign fire       = sel ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign sel_op     = sel ? req1_op : req0_op;
  assign sel_a      = sel ? req1_a  : req0_a;
  assign sel_b      = sel ? req1_b  : req0_b;

  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) &&  grant_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp_fire   = grant_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    res_d   = res_q;
`ifndef ALU_ARB_FAST_EN
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
`endif
    case (state_q)
      IDLE: if (fire) begin
        grant_d = sel;
`ifdef ALU_ARB_FAST_EN
        res_d   = alu(sel_op, sel_a, sel_b);
        state_d = RESP;
`else
        op_d    = sel_op;
        a_d     = sel_a;
        b_d     = sel_b;
        state_d = EXEC;
`endif
      end
`ifndef ALU_ARB_FAST_EN
      EXEC: begin
        res_d   = alu(op_q, a_q, b_q);
        state_d = RESP;
      end
`endif
      RESP: if (rsp_fire) begin
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      res_q   <= '0;
`ifndef ALU_ARB_FAST_EN
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      res_q   <= res_d;
`ifndef ALU_ARB_FAST_EN
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, arbitration, backpressure, async reset.
module tb_alu_arbiter;
`ifdef ALU_ARB_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp0_data, rsp1_data;
  int          total = 0, fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input bit id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
    int n;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk({tag, "_rdy"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(id ? rsp1_valid : rsp0_valid) && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_data"}, id ? rsp1_data : rsp0_data, exp);
    chk({tag, "_other"}, 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
    if (id) rsp1_ready = 1; else rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    int n;
    logic [31:0] held;

    do_reset();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_gid",   32'(grant_id), 32'd0);
    chk("rst_v0",    32'(rsp0_valid), 32'd0);
    chk("rst_v1",    32'(rsp1_valid), 32'd0);
    chk("rst_data",  rsp0_data, 32'd0);

    run_op(0, 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, "xor0");
    run_op(0, 3'b011, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, "and0");

    // Contested from reset: grants must alternate 0,1,0,1.
    do_reset();
    req0_valid = 1; req0_op = 3'b000; req0_a = 32'hFFFFFFFF; req0_b = 32'h1;
    req1_valid = 1; req1_op = 3'b001; req1_a = 32'h0;        req1_b = 32'h1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("rr%0d_gnt", i), 32'(req1_ready), 32'(i & 1));
      n = 0;
      do begin @(negedge clk); n++; end while (!(rsp0_valid || rsp1_valid) && n < 20);
      chk($sformatf("rr%0d_gid", i), 32'(grant_id), 32'(i & 1));
      chk($sformatf("rr%0d_data", i), rsp0_valid ? rsp0_data : rsp1_data,
          (i & 1) ? 32'hFFFFFFFF : 32'h0);
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;

    run_op(1, 3'b101, 32'h1,        32'd33, 32'h2, "sll1");
    run_op(1, 3'b110, 32'h80000000, 32'd31, 32'h1, "srl1");
    run_op(1, 3'b111, 32'h80000000, 32'h1,  32'h1, "slt1");
    run_op(0, 3'b111, 32'h1, 32'h80000000,  32'h0, "slt0");
    run_op(0, 3'b100, 32'h00F0000F, 32'h0F00F000, 32'h0FF0F00F, "or0");

    // Backpressure on rsp0 while req1 waits.
    req0_valid = 1; req0_op = 3'b001; req0_a = 32'd10; req0_b = 32'd3;
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_op = 3'b000; req1_a = 32'd2; req1_b = 32'd3;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp0_valid && n < 20);
    chk("bp_lat", 32'(n), 32'(LAT));
    held = rsp0_data;
    chk("bp_data", held, 32'd7);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("bp%0d_v", i),  32'(rsp0_valid), 32'd1);
      chk($sformatf("bp%0d_d", i),  rsp0_data, held);
      chk($sformatf("bp%0d_r1", i), 32'(req1_ready), 32'd0);
    end
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    chk("bp_r1_next", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp1_valid && n < 20);
    chk("bp_r1_data", rsp1_data, 32'd5);
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;

    // Serve req0 so prio points at 1, then reset mid-operation of req1.
    run_op(0, 3'b000, 32'd1, 32'd1, 32'd2, "pre_rst");
    req1_valid = 1; req1_op = 3'b000; req1_a = 32'd4; req1_b = 32'd4;
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_gid",  32'(grant_id), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_gid",  32'(grant_id), 32'd0);
    chk("ar_v1",   32'(rsp1_valid), 32'd0);
    chk("ar_data", rsp1_data, 32'd0);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp0_valid || rsp1_valid) n++; end
    chk("ar_norsp", 32'(n), 32'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("ar_prio_r0", 32'(req0_ready), 32'd1);
    chk("ar_prio_r1", 32'(req1_ready), 32'd0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit integer ALU (add/sub/xor/and/or/shift/slt) between two requesters, e.g. the EXU and the LSU address path.
- Round-robin arbitration with a valid/ready request channel and a valid/ready response channel per requester.
- Operands are registered on grant. The result is registered and held until the owning requester consumes it.
- Only one operation is in flight at a time.

Parameters:
- W, 32, datapath width; must be at least 2.
- SHW, 5, number of low bits of operand b used as the shift amount; equals log2(W).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 presents an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  opcode: 000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 SLL, 110 SRL, 111 SLT (signed)
- req0_a  in  W  operand a
- req0_b  in  W  operand b
- rsp0_valid  out  1  result for requester 0 is available
- rsp0_ready  in  1  requester 0 consumes the result
- rsp0_data  out  W  result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: identical to the port-0 set, for requester 1.
- busy  out  1  high whenever the FSM is not in IDLE
- grant_id  out  1  requester owning the current or last operation

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state=IDLE, prio=0, grant_id=0, all rspN_valid=0, rspN_data=0, busy=0, operand and op registers=0.
- IDLE:
  - reqN_ready is combinational and asserts only in IDLE.
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester indicated by prio is granted.
  - Exactly one reqN_ready is high in a given cycle. Handshake = valid & ready.
  - On handshake: latch op/a/b, set grant_id, go to EXEC.
- EXEC (one cycle): compute the ALU result from the latched operands into the result register, then go to RESP.
- RESP:
  - rsp[grant_id]_valid=1; the other rspN_valid stays 0.
  - rspN_data equals the result register and stays stable while valid and not ready.
  - On rsp handshake: clear valid, set prio = ~grant_id, go to IDLE.
  - RESP has no timeout.
- Latency: request handshake in cycle T gives rsp_valid in cycle T+2. Minimum occupancy is 3 cycles per operation. A new request is acceptable in the cycle after the response handshake.
- Arithmetic:
  - ADD and SUB wrap modulo 2^W.
  - Shifts use b[SHW-1:0] and are logical.
  - SLT is a signed compare with result 0 or 1, zero-extended.
  - XOR, AND and OR are bitwise.
- Fairness: after serving requester N, the other requester wins the next contested cycle. A requester asserting valid continuously is served within at most 2 operations.
- Requests arriving while busy are not acknowledged. Requesters must hold valid and operands stable until ready.
- rspN_valid never asserts without a prior accepted request from requester N.
- Reset mid-operation: everything returns to reset values asynchronously. The in-flight operation is dropped and its requester must reissue it.
- Deasserting reqN_valid in IDLE with no handshake has no effect.

Optional Feature:
- ALU_ARB_FAST_EN defined:
  - The EXEC state is removed. The result is computed combinationally from the request-port operands and registered in the handshake cycle, and the FSM goes IDLE -> RESP.
  - Latency becomes T+1; minimum occupancy is 2 cycles.
- ALU_ARB_FAST_EN undefined: the 3-state behaviour above applies, and the ALU sees registered operands only, which keeps the path from request ports to ALU timing-clean.

Test Plan:
- Only req0 asserts XOR, a=0xFFFF0000, b=0x0F0F0F0F -> req0_ready at T; rsp0_valid at T+2 with rsp0_data=0xF0F00F0F; rsp1_valid stays 0.
- req0 and req1 both assert from reset, ADD 0xFFFFFFFF+0x1 and SUB 0x0-0x1, rsp ready tied high -> req0 granted first with result 0x00000000, then req1 with result 0xFFFFFFFF; grants alternate 0,1,0,1 over 4 operations.
- req1 SLL a=0x1, b=33 -> result 0x2. SRL a=0x80000000, b=31 -> 0x1. SLT a=0x80000000, b=0x1 -> 0x1.
- rsp0_ready held low for 5 cycles in RESP -> rsp0_valid and rsp0_data are stable all 5 cycles; req1 with valid high sees req1_ready=0 throughout; req1 is granted the cycle after the rsp0 handshake.
- rst_n pulsed low during EXEC -> outputs return to reset values immediately without waiting for clk; no rsp_valid after release until a new request; prio=0.
- With ALU_ARB_FAST_EN: AND 0xFF00FF00 & 0x0FF00FF0 -> rsp_valid at T+1 with data 0x0F000F00.
